// File: rtl/pito_irq_queue_pkg.sv
// Shared types and defaults for the pito interrupt event queue.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pito_irq_queue_pkg;

   localparam int PITO_NUM_HARTS = 8;
   localparam int HART_CNT_WIDTH = $clog2(PITO_NUM_HARTS);
   localparam int IRQ_Q_DEPTH    = 4;
   localparam int IRQ_DATA_W     = 32;
   localparam int IRQ_NUM_SRC    = 2;

   // MVU interrupt line; the pending output lands on this mip bit
   localparam int IRQ_MVU_INTR   = 16;
   localparam int MIP_MVIP       = IRQ_MVU_INTR;

   // hart_id MSB set means broadcast to every hart
   typedef struct packed {
      logic                      valid;
      logic [HART_CNT_WIDTH:0]   hart_id;
      logic [IRQ_DATA_W-1:0]     data;
   } irq_evt_t;

   typedef logic [7:0] irq_ovf_cnt_t;

   // Drop counter increment that sticks at all-ones
   function automatic irq_ovf_cnt_t ovf_sat_inc(input irq_ovf_cnt_t c);
      return (c == 8'hFF) ? c : c + 8'd1;
   endfunction

endpackage

// File: rtl/pito_irq_queue_if.sv
// Event producer / CSR-file side bundle of the interrupt event queue.
// Latency: n/a (wires only).
// Backpressure: evt_ready_o grants at most one source per cycle.
interface pito_irq_queue_if
   import pito_irq_queue_pkg::*;
#(
   parameter int NUM_SRC   = IRQ_NUM_SRC,
   parameter int NUM_HARTS = PITO_NUM_HARTS,
   parameter int DATA_W    = IRQ_DATA_W
);
   irq_evt_t     [NUM_SRC-1:0]               evt_i;
   logic         [NUM_SRC-1:0]               evt_ready_o;
   logic         [NUM_HARTS-1:0]             irq_pending_o;
   logic         [NUM_HARTS-1:0][DATA_W-1:0] irq_data_o;
   logic         [NUM_HARTS-1:0]             irq_ack_i;
   logic         [NUM_HARTS-1:0]             q_full_o;
   irq_ovf_cnt_t [NUM_HARTS-1:0]             ovf_cnt_o;

   // producers and CSR file
   modport master (
      output evt_i, irq_ack_i,
      input  evt_ready_o, irq_pending_o, irq_data_o, q_full_o, ovf_cnt_o
   );

   // the queue itself
   modport slave (
      input  evt_i, irq_ack_i,
      output evt_ready_o, irq_pending_o, irq_data_o, q_full_o, ovf_cnt_o
   );
endinterface

// File: rtl/pito_irq_fifo.sv
// Single-hart interrupt event FIFO with push/pop/full/empty/head.
// Latency: push visible at head 1 cycle later; pop advances head next cycle.
// Backpressure: none; a push while full is accepted only when a pop happens too.
module pito_irq_fifo #(
   parameter int DEPTH = 4,
   parameter int DW    = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push_i,
   input  logic [DW-1:0] push_dat_i,
   input  logic          pop_i,
   output logic          full_o,
   output logic          empty_o,
   output logic [DW-1:0] head_o
);
   localparam int AW = $clog2(DEPTH);

   logic [AW:0]   wr_q, wr_d, rd_q, rd_d;
   logic [DW-1:0] mem_q [DEPTH];
   logic          do_push, do_pop;

   // extra pointer MSB separates full from empty
   assign empty_o = (wr_q == rd_q);
   assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);
   // an empty queue reads as zero rather than stale payload
   assign head_o  = empty_o ? '0 : mem_q[rd_q[AW-1:0]];

   // pointer next-state, wrapping by natural overflow
   always_comb begin
      wr_d = wr_q + (AW+1)'(do_push);
      rd_d = rd_q + (AW+1)'(do_pop);
   end

   // pointer registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
      end
   end

   // storage; when full the write slot is the head being popped
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (do_push) begin
         mem_q[wr_q[AW-1:0]] <= push_dat_i;
      end
   end
endmodule

// File: rtl/pito_irq_queue.sv
// Round-robin event arbiter routing into per-hart FIFOs; optional drop counters (PITO_IRQ_OVF_CNT_EN).
// Latency: granted event pending at target hart(s) 1 cycle later; ack pops next cycle.
// Backpressure: granted events are never stalled; full harts drop (and count when enabled).
module pito_irq_queue
   import pito_irq_queue_pkg::*;
#(
   parameter int NUM_HARTS = PITO_NUM_HARTS,
   parameter int NUM_SRC   = IRQ_NUM_SRC,
   parameter int Q_DEPTH   = IRQ_Q_DEPTH,
   parameter int DATA_W    = IRQ_DATA_W
) (
   input logic               clk,
   input logic               rst_n,
   pito_irq_queue_if.slave   bus
);
   localparam int SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

   logic [SRC_W-1:0]          rr_q, rr_d, win_idx, cand;
   logic [NUM_SRC-1:0]        gnt;
   logic                      gnt_vld;
   irq_evt_t                  win_evt;
   logic                      bcast, tgt_ok;
   logic [HART_CNT_WIDTH-1:0] tgt;
   logic [NUM_HARTS-1:0]      push, full, empty;

   // round-robin pick: first valid source at or after the pointer
   always_comb begin
      gnt     = '0;
      gnt_vld = 1'b0;
      win_idx = '0;
      cand    = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         cand = SRC_W'((int'(rr_q) + i) % NUM_SRC);
         if (!gnt_vld && bus.evt_i[cand].valid) begin
            gnt_vld   = 1'b1;
            win_idx   = cand;
            gnt[cand] = 1'b1;
         end
      end
      rr_d = (int'(win_idx) == NUM_SRC - 1) ? '0 : win_idx + SRC_W'(1);
   end

   assign bus.evt_ready_o = gnt;

   // pointer moves past the winner only when something was granted
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       rr_q <= '0;
      else if (gnt_vld) rr_q <= rr_d;
   end

   // decode of the winning event's destination
   assign win_evt = bus.evt_i[win_idx];
   assign bcast   = win_evt.hart_id[HART_CNT_WIDTH];
   assign tgt     = win_evt.hart_id[HART_CNT_WIDTH-1:0];
   assign tgt_ok  = (int'(tgt) < NUM_HARTS);

   for (genvar h = 0; h < NUM_HARTS; h++) begin : g_hart
      // unicast to a nonexistent hart reaches nobody
      assign push[h] = gnt_vld && (bcast || (tgt_ok && (int'(tgt) == h)));

      pito_irq_fifo #(
         .DEPTH (Q_DEPTH),
         .DW    (DATA_W)
      ) u_fifo (
         .clk        (clk),
         .rst_n      (rst_n),
         .push_i     (push[h]),
         .push_dat_i (win_evt.data),
         .pop_i      (bus.irq_ack_i[h]),
         .full_o     (full[h]),
         .empty_o    (empty[h]),
         .head_o     (bus.irq_data_o[h])
      );

      // pending feeds mip[MIP_MVIP] in the CSR file
      assign bus.irq_pending_o[h] = !empty[h];
      assign bus.q_full_o[h]      = full[h];

`ifdef PITO_IRQ_OVF_CNT_EN
      logic         drop;
      irq_ovf_cnt_t ovf_q;

      // a push is lost only when full with no simultaneous pop
      assign drop = push[h] && full[h] && !bus.irq_ack_i[h];

      // saturating per-hart drop counter, cleared only by reset
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n)    ovf_q <= '0;
         else if (drop) ovf_q <= ovf_sat_inc(ovf_q);
      end

      assign bus.ovf_cnt_o[h] = ovf_q;
`else
      assign bus.ovf_cnt_o[h] = '0;
`endif
   end
endmodule

// File: tb/tb_pito_irq_queue.sv
// Directed bench for pito_irq_queue with a per-hart scoreboard model.
// Latency: checks outputs 1 ns after each rising edge.
// Backpressure: models round-robin grant and drop-on-full behaviour.
module tb_pito_irq_queue;
   import pito_irq_queue_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   pito_irq_queue_if #(.NUM_SRC(2), .NUM_HARTS(8), .DATA_W(32)) bus_a ();
   pito_irq_queue_if #(.NUM_SRC(2), .NUM_HARTS(6), .DATA_W(32)) bus_b ();

   pito_irq_queue #(.NUM_HARTS(8), .NUM_SRC(2), .Q_DEPTH(4), .DATA_W(32)) dut_a (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_a.slave)
   );

   pito_irq_queue #(.NUM_HARTS(6), .NUM_SRC(2), .Q_DEPTH(4), .DATA_W(32)) dut_b (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_b.slave)
   );

   int checks   = 0;
   int failures = 0;

   logic [31:0] sb [8][$];
   int          ovf_m [8];
   int          rr_m;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_push(input int h, input logic [31:0] d);
      if (sb[h].size() < 4) sb[h].push_back(d);
      else if (ovf_m[h] < 255) ovf_m[h]++;
   endtask

   task automatic model_reset();
      for (int h = 0; h < 8; h++) begin
         sb[h].delete();
         ovf_m[h] = 0;
      end
      rr_m = 0;
   endtask

   task automatic check_state(input string tag);
      logic [7:0]  ep, ef;
      logic [63:0] eo;
      logic [31:0] eh;
      ep = '0; ef = '0; eo = '0;
      for (int h = 0; h < 8; h++) begin
         ep[h] = (sb[h].size() != 0);
         ef[h] = (sb[h].size() == 4);
`ifdef PITO_IRQ_OVF_CNT_EN
         eo[h*8 +: 8] = 8'(ovf_m[h]);
`endif
         eh = (sb[h].size() != 0) ? sb[h][0] : 32'h0;
         chk($sformatf("%s_head%0d", tag, h), 64'(bus_a.irq_data_o[h]), 64'(eh));
      end
      chk({tag, "_pending"}, 64'(bus_a.irq_pending_o), 64'(ep));
      chk({tag, "_full"},    64'(bus_a.q_full_o),      64'(ef));
      chk({tag, "_ovf"},     64'(bus_a.ovf_cnt_o),     eo);
   endtask

   // one cycle of stimulus on dut_a; grant and pops checked before the edge
   task automatic drive(input logic v0, input logic [3:0] h0, input logic [31:0] d0,
                        input logic v1, input logic [3:0] h1, input logic [31:0] d1,
                        input logic [7:0] ack, input string tag);
      logic        vv [2];
      logic [3:0]  hh [2];
      logic [31:0] dd [2];
      logic [31:0] hd;
      logic [1:0]  er;
      int          win, idx;
      vv[0] = v0; hh[0] = h0; dd[0] = d0;
      vv[1] = v1; hh[1] = h1; dd[1] = d1;
      bus_a.evt_i[0] = {v0, h0, d0};
      bus_a.evt_i[1] = {v1, h1, d1};
      bus_a.irq_ack_i = ack;
      #1;
      win = -1;
      for (int i = 0; i < 2; i++) begin
         idx = (rr_m + i) % 2;
         if (win < 0 && vv[idx]) win = idx;
      end
      er = (win >= 0) ? (2'b01 << win) : 2'b00;
      chk({tag, "_rdy"}, 64'(bus_a.evt_ready_o), 64'(er));
      for (int h = 0; h < 8; h++) begin
         if (ack[h] && sb[h].size() > 0) begin
            hd = sb[h].pop_front();
            chk($sformatf("%s_pop%0d", tag, h), 64'(bus_a.irq_data_o[h]), 64'(hd));
         end
      end
      if (win >= 0) begin
         rr_m = (win + 1) % 2;
         if (hh[win][3]) begin
            for (int h = 0; h < 8; h++) model_push(h, dd[win]);
         end else begin
            model_push(int'(hh[win][2:0]), dd[win]);
         end
      end
      @(posedge clk);
      #1;
      bus_a.evt_i = '0;
      bus_a.irq_ack_i = '0;
      check_state(tag);
   endtask

   initial begin
      bus_a.evt_i = '0;
      bus_a.irq_ack_i = '0;
      bus_b.evt_i = '0;
      bus_b.irq_ack_i = '0;
      model_reset();

      // reset values
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_state("rst");
      chk("rst_rdy", 64'(bus_a.evt_ready_o), 64'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // unicast to hart 3, then ack
      drive(1'b1, 4'd3, 32'hDEAD_BEEF, 1'b0, 4'd0, 32'h0, 8'h00, "uni3");
      chk("uni3_pend", 64'(bus_a.irq_pending_o[3]), 64'h1);
      drive(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 8'h08, "ack3");

      // both sources competing for hart 0
      for (int i = 0; i < 4; i++)
         drive(1'b1, 4'd0, 32'hA000_0000 + i, 1'b1, 4'd0, 32'hB000_0000 + i, 8'h00, "rr");
      chk("rr_full0", 64'(bus_a.q_full_o[0]), 64'h1);
      for (int i = 0; i < 4; i++)
         drive(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 8'h01, "drain0");

      // fill hart 2, drop 3, then saturate the counter
      for (int i = 0; i < 7; i++)
         drive(1'b1, 4'd2, 32'h2000_0000 + i, 1'b0, 4'd0, 32'h0, 8'h00, "fill2");
      for (int i = 0; i < 300; i++)
         drive(1'b0, 4'd0, 32'h0, 1'b1, 4'd2, 32'h2200_0000 + i, 8'h00, "sat2");
      for (int i = 0; i < 4; i++)
         drive(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 8'h04, "drain2");

      // push and ack on a full hart 5
      for (int i = 0; i < 4; i++)
         drive(1'b1, 4'd5, 32'h5000_0000 + i, 1'b0, 4'd0, 32'h0, 8'h00, "fill5");
      drive(1'b1, 4'd5, 32'h5555_0005, 1'b0, 4'd0, 32'h0, 8'h20, "pp5");
      chk("pp5_head", 64'(bus_a.irq_data_o[5]), 64'h5000_0001);
      for (int i = 0; i < 4; i++)
         drive(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 8'h20, "drain5");

      // push and ack on an empty hart 4
      drive(1'b1, 4'd4, 32'h4444_4444, 1'b0, 4'd0, 32'h0, 8'h10, "pp4");
      drive(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 8'h10, "drain4");

      // broadcast with hart 1 full
      for (int i = 0; i < 4; i++)
         drive(1'b1, 4'd1, 32'h1000_0000 + i, 1'b0, 4'd0, 32'h0, 8'h00, "fill1");
      drive(1'b0, 4'd0, 32'h0, 1'b1, 4'd8, 32'h0000_0055, 8'h00, "bcast");
      chk("bcast_pend", 64'(bus_a.irq_pending_o), 64'hFF);
      drive(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 8'hFF, "bdrain");

      // ack everything, including empty queues
      for (int i = 0; i < 4; i++)
         drive(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 8'hFF, "ackall");

      // async reset with queues occupied
      drive(1'b1, 4'd6, 32'h6666_0000, 1'b0, 4'd0, 32'h0, 8'h00, "pre_rst");
      drive(1'b1, 4'd8, 32'h8888_0000, 1'b0, 4'd0, 32'h0, 8'h00, "pre_rst");
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_state("async_rst");
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // six-hart instance: id 6 does not exist
      bus_b.evt_i[0] = {1'b1, 4'd6, 32'h0000_1234};
      #1;
      chk("inv_rdy", 64'(bus_b.evt_ready_o), 64'h1);
      @(posedge clk);
      #1;
      bus_b.evt_i = '0;
      chk("inv_pend", 64'(bus_b.irq_pending_o), 64'h0);
      chk("inv_full", 64'(bus_b.q_full_o), 64'h0);
      chk("inv_ovf",  64'(bus_b.ovf_cnt_o), 64'h0);
      bus_b.evt_i[1] = {1'b1, 4'd5, 32'h0000_5678};
      @(posedge clk);
      #1;
      bus_b.evt_i = '0;
      chk("b5_pend", 64'(bus_b.irq_pending_o), 64'h20);
      chk("b5_data", 64'(bus_b.irq_data_o[5]), 64'h5678);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
